// File: rtl/mem_arbiter_if.sv
// Bundle of the rvcpu fetch/data ports and the RAMHelper port around mem_arbiter.
// slave is the arbiter's view; master is the CPU + RAM side.
interface mem_arbiter_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_addr;
  logic        if_flush;
  logic        if_resp_valid;
  logic [31:0] if_resp_inst;
  logic        if_resp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic        d_req_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] d_wmask;
  logic        d_resp_valid;
  logic [63:0] d_resp_rdata;

  logic        ram_ren;
  logic [63:0] ram_ridx;
  logic [63:0] ram_rdata;
  logic        ram_wen;
  logic [63:0] ram_widx;
  logic [63:0] ram_wdata;
  logic [63:0] ram_wmask;

  modport slave (
    input  if_req_valid, if_addr, if_flush,
    input  d_req_valid, d_req_we, d_addr, d_wdata, d_wmask,
    input  ram_rdata,
    output if_req_ready, if_resp_valid, if_resp_inst, if_resp_err,
    output d_req_ready, d_resp_valid, d_resp_rdata,
    output ram_ren, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask
  );

  modport master (
    output if_req_valid, if_addr, if_flush,
    output d_req_valid, d_req_we, d_addr, d_wdata, d_wmask,
    output ram_rdata,
    input  if_req_ready, if_resp_valid, if_resp_inst, if_resp_err,
    input  d_req_ready, d_resp_valid, d_resp_rdata,
    input  ram_ren, ram_ridx, ram_wen, ram_widx, ram_wdata, ram_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Registered fetch/data arbiter onto the single RAMHelper port: data-over-fetch
// priority with a fetch starvation guard, responses one cycle after grant.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter logic [63:0] RAM_BASE   = 64'h8000_0000
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0]  starve_q, starve_d;
  logic        gnt_f, gnt_d, d_load;
  logic [63:0] f_idx, d_idx;

  logic        if_vld_q, if_vld_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_err_q, if_err_d;
  logic        d_vld_q, d_vld_d;
  logic [63:0] d_rdata_q, d_rdata_d;

  assign f_idx = (bus.if_addr - RAM_BASE) >> 3;
  assign d_idx = (bus.d_addr - RAM_BASE) >> 3;

  always_comb begin
    gnt_d = 1'b0;
    gnt_f = 1'b0;
    if (!reset) begin
      if (bus.d_req_valid && !(bus.if_req_valid && starve_q == STARVE_LIM)) gnt_d = 1'b1;
      else if (bus.if_req_valid)                                            gnt_f = 1'b1;
    end
  end

  assign d_load           = gnt_d && !bus.d_req_we;
  assign bus.if_req_ready = gnt_f;
  assign bus.d_req_ready  = gnt_d;

  // Ungranted lanes are driven to zero so the RAM port is quiet when idle.
  always_comb begin
    bus.ram_ren   = gnt_f || d_load;
    bus.ram_ridx  = gnt_f ? f_idx : (d_load ? d_idx : '0);
    bus.ram_wen   = gnt_d && bus.d_req_we;
    bus.ram_widx  = bus.ram_wen ? d_idx       : '0;
    bus.ram_wdata = bus.ram_wen ? bus.d_wdata : '0;
    bus.ram_wmask = bus.ram_wen ? bus.d_wmask : '0;
  end

  always_comb begin
    starve_d  = starve_q;
    if_vld_d  = gnt_f && !bus.if_flush;
    if_inst_d = if_inst_q;
    if_err_d  = if_err_q;
    d_vld_d   = gnt_d;
    d_rdata_d = d_rdata_q;

    if (!bus.if_req_valid || gnt_f) starve_d = '0;
    else if (starve_q != STARVE_LIM) starve_d = starve_q + 3'd1;

    if (if_vld_d) begin
      if_err_d  = (bus.if_addr[1:0] != 2'b00);
      if_inst_d = if_err_d ? '0 :
                  (bus.if_addr[2] ? bus.ram_rdata[63:32] : bus.ram_rdata[31:0]);
    end

    if (gnt_d) d_rdata_d = bus.d_req_we ? '0 : bus.ram_rdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q  <= '0;
      if_vld_q  <= 1'b0;
      if_inst_q <= '0;
      if_err_q  <= 1'b0;
      d_vld_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      starve_q  <= starve_d;
      if_vld_q  <= if_vld_d;
      if_inst_q <= if_inst_d;
      if_err_q  <= if_err_d;
      d_vld_q   <= d_vld_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.if_resp_valid = if_vld_q;
  assign bus.if_resp_inst  = if_inst_q;
  assign bus.if_resp_err   = if_err_q;
  assign bus.d_resp_valid  = d_vld_q;
  assign bus.d_resp_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a RAM environment plus a transaction-level
// model of grants, starvation streak and one-cycle-late responses.
module tb_mem_arbiter;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int          SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  logic init_en;

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_MAX(SMAX), .RAM_BASE(BASE)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM environment (RAMHelper stand-in), 16 words
  logic [63:0] env_mem [16];
  logic [63:0] mdl_mem [16];

  assign bus.ram_rdata = env_mem[bus.ram_ridx[3:0]];

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= mdl_mem[i];
    end else if (bus.ram_wen) begin
      env_mem[bus.ram_widx[3:0]] <= (env_mem[bus.ram_widx[3:0]] & ~bus.ram_wmask) |
                                    (bus.ram_wdata & bus.ram_wmask);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  // model state: length of the current streak of lost fetch arbitrations
  int          lost = 0;
  logic        exp_if_v = 1'b0, exp_err = 1'b0, exp_d_v = 1'b0;
  logic [31:0] exp_inst = '0;
  logic [63:0] exp_rdata = '0;

  // snapshots of combinational outputs from the most recent step
  logic        s_fr, s_dr, s_ren, s_wen;
  logic [63:0] s_ridx, s_widx;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic step(input logic r, input logic fv, input logic [63:0] fa, input logic fl,
                      input logic dv, input logic we, input logic [63:0] da,
                      input logic [63:0] wd, input logic [63:0] wm);
    logic        gf, gd;
    logic [63:0] fi, di, w;
    logic        e_ren, e_wen;
    logic [63:0] e_ridx;

    chk("if_resp_valid", bus.if_resp_valid, exp_if_v);
    chk("if_resp_inst",  bus.if_resp_inst,  exp_inst);
    chk("if_resp_err",   bus.if_resp_err,   exp_err);
    chk("d_resp_valid",  bus.d_resp_valid,  exp_d_v);
    chk("d_resp_rdata",  bus.d_resp_rdata,  exp_rdata);

    rst              = r;
    bus.if_req_valid = fv;
    bus.if_addr      = fa;
    bus.if_flush     = fl;
    bus.d_req_valid  = dv;
    bus.d_req_we     = we;
    bus.d_addr       = da;
    bus.d_wdata      = wd;
    bus.d_wmask      = wm;
    #1;

    // who wins: data by default, fetch when only it asks or it has lost SMAX times
    gd = !r && dv && !(fv && lost == SMAX);
    gf = !r && fv && !gd;
    fi = (fa - BASE) >> 3;
    di = (da - BASE) >> 3;

    e_ren  = 1'b0;
    e_wen  = 1'b0;
    e_ridx = '0;
    if (gf) begin
      e_ren = 1'b1; e_ridx = fi;
    end else if (gd && !we) begin
      e_ren = 1'b1; e_ridx = di;
    end else if (gd) begin
      e_wen = 1'b1;
    end

    chk("if_req_ready", bus.if_req_ready, gf);
    chk("d_req_ready",  bus.d_req_ready,  gd);
    chk("ram_ren",      bus.ram_ren,      e_ren);
    chk("ram_ridx",     bus.ram_ridx,     e_ridx);
    chk("ram_wen",      bus.ram_wen,      e_wen);
    chk("ram_widx",     bus.ram_widx,     e_wen ? di : 64'd0);
    chk("ram_wdata",    bus.ram_wdata,    e_wen ? wd : 64'd0);
    chk("ram_wmask",    bus.ram_wmask,    e_wen ? wm : 64'd0);

    s_fr = bus.if_req_ready; s_dr = bus.d_req_ready;
    s_ren = bus.ram_ren; s_wen = bus.ram_wen;
    s_ridx = bus.ram_ridx; s_widx = bus.ram_widx;

    if (r) begin
      lost = 0;
      exp_if_v = 1'b0; exp_inst = '0; exp_err = 1'b0;
      exp_d_v = 1'b0; exp_rdata = '0;
    end else begin
      if (fv && !gf) lost = (lost < SMAX) ? lost + 1 : lost;
      else           lost = 0;
      exp_if_v = gf && !fl;
      if (exp_if_v) begin
        exp_err  = (fa[1:0] != 2'b00);
        w        = mdl_mem[fi[3:0]];
        exp_inst = exp_err ? 32'd0 : (fa[2] ? w[63:32] : w[31:0]);
      end
      exp_d_v = gd;
      if (gd) begin
        if (we) begin
          exp_rdata = '0;
          mdl_mem[di[3:0]] = (mdl_mem[di[3:0]] & ~wm) | (wd & wm);
        end else begin
          exp_rdata = mdl_mem[di[3:0]];
        end
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, BASE, 1'b0, 1'b0, 1'b0, BASE, 64'd0, 64'd0);
  endtask

  logic [9:0] pat;

  initial begin
    rst = 1'b1;
    init_en = 1'b1;
    bus.if_req_valid = 1'b0; bus.if_addr = BASE; bus.if_flush = 1'b0;
    bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_addr = BASE;
    bus.d_wdata = '0; bus.d_wmask = '0;
    for (int i = 0; i < 16; i++) mdl_mem[i] = {$urandom, $urandom};
    mdl_mem[0] = 64'hAAAA_BBBB_1111_2222;
    @(posedge clk);
    #1;
    init_en = 1'b0;

    idle(1'b1);
    idle(1'b1);
    chk("rst_if_valid", bus.if_resp_valid, 64'd0);
    chk("rst_d_valid",  bus.d_resp_valid,  64'd0);
    chk("rst_ram_ren",  s_ren,             64'd0);
    idle(1'b0);

    // aligned fetch of the upper half of word 0
    step(1'b0, 1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b0, BASE, 64'd0, 64'd0);
    chk("fetch_ridx",  s_ridx,            64'd0);
    chk("fetch_ready", s_fr,              64'd1);
    chk("fetch_valid", bus.if_resp_valid, 64'd1);
    chk("fetch_inst",  bus.if_resp_inst,  64'hAAAA_BBBB);
    chk("fetch_err",   bus.if_resp_err,   64'd0);
    idle(1'b0);

    // continuous tie: D,D,D,D,F repeating
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, BASE + 64'(k * 8), 1'b0, 1'b1, 1'b0, BASE + 64'((k % 16) * 8),
           64'd0, 64'd0);
      pat = {pat[8:0], s_dr};
    end
    chk("starve_pattern", 64'(pat), 64'b11_1101_1110);
    idle(1'b0);

    // store then load of the same word
    step(1'b0, 1'b0, BASE, 1'b0, 1'b1, 1'b1, 64'h8000_0010, 64'h55, 64'hFF);
    chk("store_wen",  s_wen,  64'd1);
    chk("store_widx", s_widx, 64'd2);
    chk("store_ren",  s_ren,  64'd0);
    chk("store_resp_valid", bus.d_resp_valid, 64'd1);
    chk("store_resp_rdata", bus.d_resp_rdata, 64'd0);
    step(1'b0, 1'b0, BASE, 1'b0, 1'b1, 1'b0, 64'h8000_0010, 64'd0, 64'd0);
    chk("load_back_byte", bus.d_resp_rdata & 64'hFF, 64'h55);

    // flushed fetch is dropped, the following one delivered
    step(1'b0, 1'b1, BASE, 1'b1, 1'b0, 1'b0, BASE, 64'd0, 64'd0);
    chk("flush_ready", s_fr,              64'd1);
    chk("flush_drop",  bus.if_resp_valid, 64'd0);
    step(1'b0, 1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b0, BASE, 64'd0, 64'd0);
    chk("post_flush_valid", bus.if_resp_valid, 64'd1);
    chk("post_flush_inst",  bus.if_resp_inst,  64'hAAAA_BBBB);

    // misaligned fetch
    step(1'b0, 1'b1, 64'h8000_0002, 1'b0, 1'b0, 1'b0, BASE, 64'd0, 64'd0);
    chk("misalign_valid", bus.if_resp_valid, 64'd1);
    chk("misalign_err",   bus.if_resp_err,   64'd1);
    chk("misalign_inst",  bus.if_resp_inst,  64'd0);

    // reset overlapping a load, then a store
    step(1'b1, 1'b1, BASE, 1'b0, 1'b1, 1'b0, BASE + 64'd8, 64'd0, 64'd0);
    chk("rst_load_dready", s_dr, 64'd0);
    chk("rst_load_ren",    s_ren, 64'd0);
    chk("rst_load_dvalid", bus.d_resp_valid, 64'd0);
    step(1'b1, 1'b0, BASE, 1'b0, 1'b1, 1'b1, BASE + 64'd8, 64'hDEAD, '1);
    chk("rst_store_wen", s_wen, 64'd0);
    for (int k = 0; k < 6; k++)
      step(1'b0, 1'b1, BASE, 1'b0, 1'b1, 1'b0, BASE + 64'd24, 64'd0, 64'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic        r, fv, fl, dv, we;
      logic [63:0] fa, da;
      int unsigned off;
      case ($urandom_range(0, 7))
        0, 1, 2: off = 0;
        3, 4, 5: off = 4;
        6:       off = 2;
        default: off = $urandom_range(1, 7);
      endcase
      r  = ($urandom_range(0, 49) == 0);
      fv = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 7) == 0);
      dv = ($urandom_range(0, 3) != 0);
      we = $urandom_range(0, 1) != 0;
      fa = BASE + 64'($urandom_range(0, 15) * 8) + 64'(off);
      da = BASE + 64'($urandom_range(0, 15) * 8);
      step(r, fv, fa, fl, dv, we, da, {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
